fir_scale_config_master: RTL and testbench

- Initiator side of the FIR scale-configuration handshake (isConfig / isCOnfigACK / isConfigDone / config data).
- On a start pulse, sequentially programs up to four FIR output-scale stages with shift values taken from a latched table.
- Sits between the control register file and the FIR_OUT_SCALE instances of the DDC channels.
- Reports completion, or a timeout error with the failing target and phase.

---
 rtl/fir_scale_config_master.sv | 157 +++++++++++++++
 tb/tb_fir_scale_config_master.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_scale_config_master.sv
`default_nettype none
// ============================================================================
// Module      : fir_scale_config_master
// Description : Initiator side of the FIR output-scale configuration
//               handshake. On a start pulse it walks through up to four
//               responders, presenting each one's shift value from a table
//               latched at start, and reports completion or a timeout with
//               the failing target and handshake phase.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_scale_config_master #(
  parameter int FIR_CONFIG_DATA_WIDTH = 24,
  parameter int NUM_TARGETS           = 4,
  parameter int TIMEOUT_CYCLES        = 16
) (
  input  logic                                   CLK,
  input  logic                                   nRST,
  input  logic                                   Cfg_Start,
  input  logic [NUM_TARGETS*FIR_CONFIG_DATA_WIDTH-1:0] Cfg_Table_In,
  output logic [NUM_TARGETS-1:0]                 isConfig,
  output logic [FIR_CONFIG_DATA_WIDTH-1:0]       Data_Config_Out,
  input  logic [NUM_TARGETS-1:0]                 isCOnfigACK,
  input  logic [NUM_TARGETS-1:0]                 isConfigDone,
  output logic                                   Cfg_Busy,
  output logic                                   Cfg_Done,
  output logic                                   Cfg_Err,
  output logic [1:0]                             Cfg_Err_Idx,
  output logic                                   Cfg_Err_Phase
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_REQ       = 2'd1,
    S_WAIT_ACK  = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  // Timer reaching this value on a sampled edge means the wait has lasted
  // TIMEOUT_CYCLES edges without the expected event.
  localparam logic [7:0] C_TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0] C_LAST_IDX = 2'(NUM_TARGETS - 1);

  state_t                                     r_state;
  logic [1:0]                                 r_idx;
  logic [7:0]                                 r_timer;
  logic [NUM_TARGETS*FIR_CONFIG_DATA_WIDTH-1:0] r_table;

  logic [NUM_TARGETS-1:0]                     w_onehot;
  logic [FIR_CONFIG_DATA_WIDTH-1:0]           w_data;
  logic                                       w_sel_ack;
  logic                                       w_sel_done;
  logic                                       w_timeout;

  // Select the current target's request bit, table entry and handshake inputs;
  // handshakes on any other bit never reach the state machine.
  always_comb begin
    w_onehot   = '0;
    w_data     = '0;
    w_sel_ack  = 1'b0;
    w_sel_done = 1'b0;
    for (int i = 0; i < NUM_TARGETS; i++) begin
      if (r_idx == 2'(i)) begin
        w_onehot[i] = 1'b1;
        w_data      = r_table[i*FIR_CONFIG_DATA_WIDTH +: FIR_CONFIG_DATA_WIDTH];
        w_sel_ack   = isCOnfigACK[i];
        w_sel_done  = isConfigDone[i];
      end
    end
  end

  assign w_timeout = (r_timer == C_TMO_LAST);

  // Sequencer: IDLE -> (REQ -> WAIT_ACK -> WAIT_DONE) per target, all outputs registered.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state         <= S_IDLE;
      r_idx           <= 2'd0;
      r_timer         <= 8'd0;
      r_table         <= '0;
      isConfig        <= '0;
      Data_Config_Out <= '0;
      Cfg_Busy        <= 1'b0;
      Cfg_Done        <= 1'b0;
      Cfg_Err         <= 1'b0;
      Cfg_Err_Idx     <= 2'd0;
      Cfg_Err_Phase   <= 1'b0;
    end else begin
      Cfg_Done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Responder events arriving here are irrelevant; only Start matters.
          if (Cfg_Start) begin
            r_table       <= Cfg_Table_In;
            r_idx         <= 2'd0;
            Cfg_Busy      <= 1'b1;
            Cfg_Err       <= 1'b0;
            Cfg_Err_Idx   <= 2'd0;
            Cfg_Err_Phase <= 1'b0;
            r_state       <= S_REQ;
          end
        end

        S_REQ: begin
          isConfig        <= w_onehot;
          Data_Config_Out <= w_data;
          r_timer         <= 8'd0;
          r_state         <= S_WAIT_ACK;
        end

        S_WAIT_ACK: begin
          if (w_sel_ack) begin
            // Drop the request on the ACK edge so the responder never sees
            // it again once it returns to normal work.
            isConfig <= '0;
            r_timer  <= 8'd0;
            r_state  <= S_WAIT_DONE;
          end else if (w_timeout) begin
            isConfig      <= '0;
            Cfg_Err       <= 1'b1;
            Cfg_Err_Idx   <= r_idx;
            Cfg_Err_Phase <= 1'b0;
            Cfg_Busy      <= 1'b0;
            r_state       <= S_IDLE;
          end else begin
            r_timer <= r_timer + 8'd1;
          end
        end

        S_WAIT_DONE: begin
          if (w_sel_done) begin
            if (r_idx == C_LAST_IDX) begin
              Cfg_Done <= 1'b1;
              Cfg_Busy <= 1'b0;
              r_state  <= S_IDLE;
            end else begin
              r_idx   <= r_idx + 2'd1;
              r_state <= S_REQ;
            end
          end else if (w_timeout) begin
            isConfig      <= '0;
            Cfg_Err       <= 1'b1;
            Cfg_Err_Idx   <= r_idx;
            Cfg_Err_Phase <= 1'b1;
            Cfg_Busy      <= 1'b0;
            r_state       <= S_IDLE;
          end else begin
            r_timer <= r_timer + 8'd1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fir_scale_config_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_scale_config_master
// Description : Directed bench for fir_scale_config_master with four
//               behavioural responders, stray handshake injection and
//               hand-computed edge positions relative to the Start edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_scale_config_master;

  localparam int          C_W     = 24;
  localparam int          C_N     = 4;
  localparam logic [95:0] C_TABLE = {24'd1, 24'd3, 24'd5, 24'd7};
  localparam int          C_HIST  = 45;

  logic             CLK;
  logic             nRST;
  logic             Cfg_Start;
  logic [95:0]      Cfg_Table_In;
  logic [3:0]       isConfig;
  logic [C_W-1:0]   Data_Config_Out;
  logic             Cfg_Busy, Cfg_Done, Cfg_Err, Cfg_Err_Phase;
  logic [1:0]       Cfg_Err_Idx;

  logic [3:0]       r_rsp_ack, r_rsp_done;
  logic [3:0]       r_stray_ack, r_stray_done;
  logic [3:0]       r_no_ack, r_no_done;
  logic             r_clr;
  logic [1:0]       r_rs   [4];
  logic [C_W-1:0]   r_lat  [4];
  logic [7:0]       r_nreq [4];
  wire  [3:0]       w_ack  = r_rsp_ack  | r_stray_ack;
  wire  [3:0]       w_done = r_rsp_done | r_stray_done;

  logic [3:0]       h_cfg  [C_HIST];
  logic [C_W-1:0]   h_data [C_HIST];
  logic             h_busy [C_HIST];
  logic             h_err  [C_HIST];
  int               n_done_pulses, busy_cnt, first_done, first_err;

  int               n_vec, n_err;

  fir_scale_config_master #(
    .FIR_CONFIG_DATA_WIDTH (C_W),
    .NUM_TARGETS           (C_N),
    .TIMEOUT_CYCLES        (16)
  ) dut (
    .CLK             (CLK),
    .nRST            (nRST),
    .Cfg_Start       (Cfg_Start),
    .Cfg_Table_In    (Cfg_Table_In),
    .isConfig        (isConfig),
    .Data_Config_Out (Data_Config_Out),
    .isCOnfigACK     (w_ack),
    .isConfigDone    (w_done),
    .Cfg_Busy        (Cfg_Busy),
    .Cfg_Done        (Cfg_Done),
    .Cfg_Err         (Cfg_Err),
    .Cfg_Err_Idx     (Cfg_Err_Idx),
    .Cfg_Err_Phase   (Cfg_Err_Phase)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Standard responder: ACK one edge after seeing the request, latch data and
  // drop ACK on the next edge, then a one-cycle Done pulse two edges later.
  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < 4; i++) begin
        r_rs[i]       <= 2'd0;
        r_rsp_ack[i]  <= 1'b0;
        r_rsp_done[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        case (r_rs[i])
          2'd0: if (isConfig[i] && !r_no_ack[i]) begin
                  r_rsp_ack[i] <= 1'b1;
                  r_nreq[i]    <= r_nreq[i] + 8'd1;
                  r_rs[i]      <= 2'd1;
                end
          2'd1: begin
                  r_rsp_ack[i] <= 1'b0;
                  r_lat[i]     <= Data_Config_Out;
                  r_rs[i]      <= 2'd2;
                end
          2'd2: begin
                  if (!r_no_done[i]) begin
                    r_rsp_done[i] <= 1'b1;
                    r_rs[i]       <= 2'd3;
                  end else begin
                    r_rs[i] <= 2'd0;
                  end
                end
          default: begin
                  r_rsp_done[i] <= 1'b0;
                  r_rs[i]       <= 2'd0;
                end
        endcase
        if (r_clr) begin
          r_lat[i]  <= '0;
          r_nreq[i] <= 8'd0;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One sequence: Start sampled at edge k, history recorded at the negedge
  // following edges k+0 .. k+44. mode 1 adds stray handshakes, mode 2 a
  // second Start with a zero table at edge k+4.
  task automatic run_seq(input int mode);
    n_done_pulses = 0;
    busy_cnt      = 0;
    first_done    = -1;
    first_err     = -1;
    @(negedge CLK);
    r_clr        = 1'b1;
    Cfg_Start    = 1'b1;
    Cfg_Table_In = C_TABLE;
    r_stray_ack  = (mode == 1) ? 4'hF : 4'h0;
    r_stray_done = (mode == 1) ? 4'hF : 4'h0;
    @(negedge CLK);
    r_clr     = 1'b0;
    Cfg_Start = 1'b0;
    for (int n = 0; n < C_HIST; n++) begin
      if (n > 0) @(negedge CLK);
      h_cfg[n]  = isConfig;
      h_data[n] = Data_Config_Out;
      h_busy[n] = Cfg_Busy;
      h_err[n]  = Cfg_Err;
      if (Cfg_Busy) busy_cnt++;
      if (Cfg_Done) begin
        n_done_pulses++;
        if (first_done < 0) first_done = n;
      end
      if (Cfg_Err && first_err < 0) first_err = n;
      r_stray_ack  = (mode == 1 && n < 5) ? 4'b1110 : 4'b0000;
      r_stray_done = (mode == 1 && n < 5) ? 4'b1110 : 4'b0000;
      if (mode == 2 && n == 3) begin
        Cfg_Start    = 1'b1;
        Cfg_Table_In = '0;
      end
      if (mode == 2 && n == 4) begin
        Cfg_Start    = 1'b0;
        Cfg_Table_In = C_TABLE;
      end
    end
  endtask

  task automatic check_nominal(input string t);
    check({t, "_busy_k0"},   32'(h_busy[0]), 32'd1);
    check({t, "_err_k0"},    32'(h_err[0]),  32'd0);
    check({t, "_req0"},      32'(h_cfg[1]),  32'h1);
    check({t, "_data0"},     32'(h_data[1]), 32'd7);
    check({t, "_req0_drop"}, 32'(h_cfg[3]),  32'h0);
    check({t, "_data_hold"}, 32'(h_data[3]), 32'd7);
    check({t, "_req1"},      32'(h_cfg[6]),  32'h2);
    check({t, "_req2"},      32'(h_cfg[11]), 32'h4);
    check({t, "_req3"},      32'(h_cfg[16]), 32'h8);
    check({t, "_data3"},     32'(h_data[16]), 32'd1);
    check({t, "_done_edge"}, 32'(first_done), 32'd20);
    check({t, "_done_cnt"},  32'(n_done_pulses), 32'd1);
    check({t, "_busy_cnt"},  32'(busy_cnt), 32'd20);
    check({t, "_busy_fall"}, 32'(h_busy[20]), 32'd0);
    check({t, "_no_err"},    32'(first_err), 32'hFFFF_FFFF);
    check({t, "_data_end"},  32'(h_data[44]), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_lat%0d", t, i), 32'(r_lat[i]), 32'(7 - 2*i));
      check($sformatf("%s_nreq%0d", t, i), 32'(r_nreq[i]), 32'd1);
    end
  endtask

  task automatic check_reset_outputs(input string t);
    check({t, "_cfg"},   32'(isConfig),        32'd0);
    check({t, "_data"},  32'(Data_Config_Out), 32'd0);
    check({t, "_busy"},  32'(Cfg_Busy),        32'd0);
    check({t, "_done"},  32'(Cfg_Done),        32'd0);
    check({t, "_err"},   32'(Cfg_Err),         32'd0);
    check({t, "_eidx"},  32'(Cfg_Err_Idx),     32'd0);
    check({t, "_ephs"},  32'(Cfg_Err_Phase),   32'd0);
  endtask

  initial begin
    n_vec        = 0;
    n_err        = 0;
    nRST         = 1'b0;
    Cfg_Start    = 1'b0;
    Cfg_Table_In = C_TABLE;
    r_stray_ack  = 4'h0;
    r_stray_done = 4'h0;
    r_no_ack     = 4'h0;
    r_no_done    = 4'h0;
    r_clr        = 1'b0;
    repeat (3) @(negedge CLK);
    check_reset_outputs("rst");
    nRST = 1'b1;
    repeat (2) @(negedge CLK);

    run_seq(0);
    check_nominal("nom");

    run_seq(1);
    check_nominal("stray");

    run_seq(2);
    check_nominal("busy_start");

    // Responder 2 never acknowledges: REQ at k+11, 16th waiting edge is k+27.
    r_no_ack = 4'b0100;
    run_seq(0);
    check("acktmo_req2",     32'(h_cfg[26]),  32'h4);
    check("acktmo_busy26",   32'(h_busy[26]), 32'd1);
    check("acktmo_err_edge", 32'(first_err),  32'd27);
    check("acktmo_cfg_drop", 32'(h_cfg[27]),  32'h0);
    check("acktmo_busy27",   32'(h_busy[27]), 32'd0);
    check("acktmo_eidx",     32'(Cfg_Err_Idx),   32'd2);
    check("acktmo_ephs",     32'(Cfg_Err_Phase), 32'd0);
    check("acktmo_no_done",  32'(n_done_pulses), 32'd0);
    check("acktmo_nreq3",    32'(r_nreq[3]),     32'd0);
    r_no_ack = 4'h0;

    // Responder 1 never signals Done: ACK sampled at k+8, timeout at k+24.
    r_no_done = 4'b0010;
    run_seq(0);
    check("dntmo_err23",    32'(h_err[23]),     32'd0);
    check("dntmo_err_edge", 32'(first_err),     32'd24);
    check("dntmo_eidx",     32'(Cfg_Err_Idx),   32'd1);
    check("dntmo_ephs",     32'(Cfg_Err_Phase), 32'd1);
    check("dntmo_no_done",  32'(n_done_pulses), 32'd0);
    check("dntmo_lat1",     32'(r_lat[1]),      32'd5);
    check("dntmo_nreq2",    32'(r_nreq[2]),     32'd0);
    r_no_done = 4'h0;
    run_seq(0);
    check_nominal("after_dntmo");

    // Reset while target 1 is in WAIT_DONE (edges k+8..k+10).
    @(negedge CLK);
    r_clr     = 1'b1;
    Cfg_Start = 1'b1;
    @(negedge CLK);
    r_clr     = 1'b0;
    Cfg_Start = 1'b0;
    repeat (9) @(negedge CLK);
    check("midrst_busy_pre", 32'(Cfg_Busy), 32'd1);
    nRST = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    run_seq(0);
    check_nominal("after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute guard so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
